// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch input conditioning path.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;

    // Width of a counter that must hold the largest of three cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Raw key inputs and conditioned outputs between the board buttons and the stopwatch core.
interface key_debouncer_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;

    modport master (output KEY, input key_level, input press_pulse, input release_pulse);
    modport slave  (input KEY, output key_level, output press_pulse, output release_pulse);
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM and registered level/pulse outputs.
// Build option KEY_AUTOREPEAT_EN adds hold-to-repeat press pulses.
module key_debounce_ch
    import cronometro_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [1:0]       sync_q;
    logic             raw_p;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;
    logic [CNT_W-1:0] hold_last;

    // First repeat waits the long delay, later ones the short period.
    assign hold_last = rep_q ? RP_LAST : RD_LAST;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Synchronizer resets to the released level so a held key is re-qualified after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign raw_p = ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            hold_q    <= '0;
            rep_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
            hold_q    <= hold_d;
            rep_q     <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        hold_d    = '0;
        rep_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (raw_p) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!raw_p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                if (!raw_p) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (hold_q == hold_last) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        hold_d = sat_inc(hold_q);
                        rep_d  = rep_q;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (raw_p) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low board buttons into clean levels and single-cycle pulses.
// Build option KEY_AUTOREPEAT_EN enables hold-to-repeat press pulses in every channel.
module key_debouncer
    import cronometro_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    key_debouncer_if.slave kif
);

    logic [N_KEYS-1:0] level_w;
    logic [N_KEYS-1:0] press_w;
    logic [N_KEYS-1:0] release_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (CLOCK_50),
            .rst       (reset),
            .key_n_i   (kif.KEY[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i])
        );
    end

    assign kif.key_level     = level_w;
    assign kif.press_pulse   = press_w;
    assign kif.release_pulse = release_w;

endmodule
